op_amp_with_frac_core: RTL and testbench

- Behavioural model of a non-inverting op-amp stage with a fixed-point fractional gain.
- Samples an unsigned input amplitude at a 100 kHz rate and applies a saturating gain.
- Models the amplifier's finite bandwidth as a first-order settling filter.
- Outputs the squared output amplitude (power estimate) for downstream level detection, and exports the 100 kHz sample clock it derives from the 100 MHz system clock.

---
 rtl/op_amp_pkg.sv | 18 +
 rtl/clk_div_tick.sv | 48 ++++
 rtl/op_amp_with_frac_core.sv | 97 +++++++++
 tb/tb_op_amp_with_frac_core.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/op_amp_pkg.sv
// ----------------------------------------------------------------------------
// op_amp_pkg
// Shared constants for the fractional-gain op-amp model.
//   DEF_CLK_DIV_HALF : system clocks per half period of the 100 kHz sample clock
//   DEF_FRAC_W       : fractional bits of the gain and of the filter state
//   DEF_GAIN         : UQ8.8 closed-loop gain (1 + Rf/Rg), 1.5 by default
//   DEF_ALPHA_SHIFT  : settling filter coefficient, alpha = 2^-DEF_ALPHA_SHIFT
//   STATE_W          : filter state width at the default FRAC_W (UQ16.FRAC_W)
//   PROD_W           : width of the raw amplitude * gain product
// ----------------------------------------------------------------------------
package op_amp_pkg;
   localparam int unsigned DEF_CLK_DIV_HALF = 500;
   localparam int unsigned DEF_FRAC_W       = 8;
   localparam logic [15:0] DEF_GAIN         = 16'h0180;
   localparam int unsigned DEF_ALPHA_SHIFT  = 4;
   localparam int unsigned STATE_W          = 16 + DEF_FRAC_W;
   localparam int unsigned PROD_W           = 32;
endpackage

// File: rtl/clk_div_tick.sv
// ----------------------------------------------------------------------------
// clk_div_tick
// Divides the system clock down to a registered 50 % duty sample clock and
// produces a one-cycle strobe coincident with each of its rising edges.
//   clk     : system clock
//   rst     : asynchronous, active-high reset
//   clk_out : divided clock, period 2*CLK_DIV_HALF system clocks, low after reset
//   tick    : high for the system cycle whose edge raises clk_out
// ----------------------------------------------------------------------------
module clk_div_tick
   import op_amp_pkg::*;
#(
   parameter int unsigned CLK_DIV_HALF = DEF_CLK_DIV_HALF
) (
   input  logic clk,
   input  logic rst,
   output logic clk_out,
   output logic tick
);

   localparam int unsigned     CNT_W    = (CLK_DIV_HALF > 1) ? $clog2(CLK_DIV_HALF) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV_HALF - 1);

   logic [CNT_W-1:0] count_d, count_q;
   logic             clk_d, clk_q;
   logic             at_last;

   always_comb begin
      at_last = (count_q == CNT_LAST);
      count_d = at_last ? '0 : count_q + CNT_W'(1);
      clk_d   = at_last ? ~clk_q : clk_q;
      // Only the low-to-high wrap is a sample point.
      tick    = at_last && !clk_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         clk_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         clk_q   <= clk_d;
      end
   end

   assign clk_out = clk_q;

endmodule

// File: rtl/op_amp_with_frac_core.sv
// ----------------------------------------------------------------------------
// op_amp_with_frac_core
// Behavioural non-inverting op-amp stage: samples the input amplitude at the
// derived 100 kHz rate, applies a saturating UQ8.8 gain, models the finite
// bandwidth with a first-order settling filter and reports output power.
//   clk        : 100 MHz system clock
//   reset_n    : asynchronous reset, active-high despite the name
//   non_inv    : unsigned amplitude at the non-inverting input
//   square_out : unsigned square of the settled output amplitude
//   clk_100k   : registered 50 % duty sample clock
// ----------------------------------------------------------------------------
module op_amp_with_frac_core
   import op_amp_pkg::*;
#(
   parameter int unsigned CLK_DIV_HALF = DEF_CLK_DIV_HALF,
   parameter int unsigned FRAC_W       = DEF_FRAC_W,
   parameter logic [15:0] GAIN         = DEF_GAIN,
   parameter int unsigned ALPHA_SHIFT  = DEF_ALPHA_SHIFT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] non_inv,
   output logic [31:0] square_out,
   output logic        clk_100k
);

   // Filter state width tracks FRAC_W; equals STATE_W at the defaults.
   localparam int unsigned Y_W = 16 + FRAC_W;

   // Clamp the integer part of the gained amplitude to the 16-bit output range.
   function automatic logic [15:0] sat_u16(input logic [PROD_W-1:0] v);
      if (v > PROD_W'(65535)) begin
         return 16'hFFFF;
      end
      return v[15:0];
   endfunction

   // One settling step toward the target. Near the target the state snaps to
   // it, otherwise the shift of a small error would stall short of it forever.
   // The step never exceeds the error, so the approach cannot overshoot.
   function automatic logic [Y_W-1:0] filter_step(input logic [Y_W-1:0] y,
                                                   input logic [15:0]  tgt);
      logic        [Y_W-1:0] tgt_fx;
      logic signed [Y_W:0]   d;
      logic signed [Y_W:0]   mag;
      logic signed [Y_W:0]   step;
      logic signed [Y_W:0]   sum;
      tgt_fx = {tgt, {FRAC_W{1'b0}}};
      d      = $signed({1'b0, tgt_fx}) - $signed({1'b0, y});
      mag    = (d < 0) ? -d : d;
      if (mag < $signed((Y_W + 1)'(1) <<< ALPHA_SHIFT)) begin
         return tgt_fx;
      end
      step = d >>> ALPHA_SHIFT;
      sum  = $signed({1'b0, y}) + step;
      return sum[Y_W-1:0];
   endfunction

   logic              tick;
   logic [PROD_W-1:0] prod;
   logic [15:0]       target;
   logic [15:0]       vout;
   logic [Y_W-1:0]    y_d, y_q;
   logic [31:0]       square_d, square_q;

   clk_div_tick #(
      .CLK_DIV_HALF(CLK_DIV_HALF)
   ) u_clk_div_tick (
      .clk    (clk),
      .rst    (reset_n),
      .clk_out(clk_100k),
      .tick   (tick)
   );

   always_comb begin
      prod     = PROD_W'(non_inv) * PROD_W'(GAIN);
      target   = sat_u16(prod >> FRAC_W);
      y_d      = tick ? filter_step(y_q, target) : y_q;
      vout     = y_q[Y_W-1:FRAC_W];
      // Squared every cycle from the held state, so it follows each update
      // by one clock and holds between ticks.
      square_d = 32'(vout) * 32'(vout);
   end

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         y_q      <= '0;
         square_q <= '0;
      end else begin
         y_q      <= y_d;
         square_q <= square_d;
      end
   end

   assign square_out = square_q;

endmodule

// File: tb/tb_op_amp_with_frac_core.sv
module tb_op_amp_with_frac_core;

   // Divider shortened so that full settling runs fit a short simulation.
   localparam int HALF = 10;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [15:0] non_inv = '0;
   logic [31:0] square_out;
   logic        clk_100k;

   int checks = 0;
   int errors = 0;

   op_amp_with_frac_core #(
      .CLK_DIV_HALF(HALF)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .non_inv   (non_inv),
      .square_out(square_out),
      .clk_100k  (clk_100k)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint unsigned act,
                      input longint unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic longint target_of(input longint x);
      longint t;
      t = (x * 384) / 256;
      if (t > 65535) t = 65535;
      return t;
   endfunction

   longint          m_y = 0;
   longint unsigned m_sq = 0;
   longint          m_n = 0;
   bit              model_ok = 1'b0;

   always @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         m_y  = 0;
         m_sq = 0;
         m_n  = 0;
      end else begin
         longint d;
         longint tfx;
         m_sq = longint'(m_y / 256) * longint'(m_y / 256);
         m_n++;
         if (m_n % (2 * HALF) == HALF) begin
            tfx = target_of(longint'(non_inv)) * 256;
            d   = tfx - m_y;
            if (d < 16 && d > -16) m_y = tfx;
            else m_y = m_y + (d >>> 4);
         end
      end
   end

   always @(negedge clk) begin
      if (model_ok && !reset_n) begin
         chk("model_square", square_out, m_sq);
         chk("model_clk", clk_100k, longint'((m_n / HALF) % 2));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset(input logic [15:0] x);
      @(posedge clk); #1;
      reset_n = 1'b1;
      non_inv = x;
      repeat (10) @(posedge clk);
      #1;
      reset_n = 1'b0;
   endtask

   task automatic settle(input string name, input longint unsigned exp, input int dir);
      longint unsigned prev;
      bit mono;
      prev = square_out;
      mono = 1'b1;
      for (int c = 0; c < 400 * 2 * HALF; c++) begin
         @(posedge clk); #1;
         if (dir > 0 && (square_out < prev || square_out > exp)) mono = 1'b0;
         if (dir < 0 && (square_out > prev || square_out < exp)) mono = 1'b0;
         prev = square_out;
         if (square_out == exp) break;
      end
      chk({name, "_reach"}, square_out, exp);
      chk({name, "_mono"}, mono, 1);
      repeat (6 * HALF) @(posedge clk);
      #1;
      chk({name, "_hold"}, square_out, exp);
   endtask

   // Cycles from reset release until square_out first becomes nonzero.
   task automatic first_nonzero(input string name, input longint unsigned exp_val);
      int k;
      k = 0;
      for (int c = 0; c < 4 * HALF; c++) begin
         @(posedge clk); #1;
         k++;
         if (square_out != 0) break;
      end
      chk({name, "_latency"}, k, HALF + 1);
      chk({name, "_value"}, square_out, exp_val);
   endtask

   initial begin
      int k;

      // Reset state and divider timing with zero input.
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_square", square_out, 0);
      chk("reset_clk", clk_100k, 0);
      do_reset(16'd0);
      model_ok = 1'b1;
      k = 0;
      for (int c = 0; c < 4 * HALF; c++) begin
         @(posedge clk); #1; k++;
         if (clk_100k) break;
      end
      chk("first_rise", k, HALF);
      k = 0;
      for (int c = 0; c < 4 * HALF; c++) begin
         @(posedge clk); #1; k++;
         if (!clk_100k) break;
      end
      chk("high_phase", k, HALF);
      k = 0;
      for (int c = 0; c < 4 * HALF; c++) begin
         @(posedge clk); #1; k++;
         if (clk_100k) break;
      end
      chk("low_phase", k, HALF);
      repeat (4 * HALF) @(posedge clk);
      #1;
      chk("zero_input_square", square_out, 0);

      // First step: 100 -> target 150, first tick y=2400, vout=9.
      do_reset(16'd100);
      first_nonzero("step100", 81);
      settle("step100", 22500, 1);

      // Truncated gain on small input.
      do_reset(16'd7);
      settle("small7", 100, 1);

      // Sweep with reset between steps.
      for (int i = 7; i <= 107; i += 10) begin
         longint unsigned e;
         e = longint'((i * 384) / 256) * longint'((i * 384) / 256);
         do_reset(16'(i));
         settle($sformatf("sweep%0d", i), e, 1);
      end

      // Saturation, monotone rise means no wrap on the way up.
      do_reset(16'hFFFF);
      settle("sat", 64'd4294836225, 1);

      // Mid-run asynchronous reset.
      do_reset(16'd400);
      repeat (30 * 2 * HALF) @(posedge clk);
      #1;
      chk("pre_reset_nonzero", (square_out != 0), 1);
      @(posedge clk); #2;
      reset_n = 1'b1;
      #1;
      chk("async_square", square_out, 0);
      chk("async_clk", clk_100k, 0);
      repeat (5) @(posedge clk);
      #1;
      reset_n = 1'b0;
      first_nonzero("restart400", 1369);

      // Input change without reset: settle high, then decay.
      do_reset(16'd2200);
      settle("hold2200", 64'd10890000, 1);
      @(posedge clk); #1;
      non_inv = 16'd1000;
      settle("drop1000", 64'd2250000, -1);

      model_ok = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
